// File: rtl/svc_rv_mmio_uart_tx_pkg.sv
// svc_rv_mmio_uart_tx_pkg
// Shared constants for the MMIO UART transmitter: register offsets (byte
// address bits [3:2]), STATUS bit positions and the transmit FSM states.
package svc_rv_mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA   = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_DIVISOR  = 2'd2;
  localparam logic [1:0] REG_RESERVED = 2'd3;

  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_EMPTY     = 2;
  localparam int STATUS_OVERFLOW  = 3;
  localparam int STATUS_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/svc_sync_fifo.sv
// svc_sync_fifo
// Small synchronous first-word-fall-through FIFO used as the UART TX buffer.
// Only built when SVC_RV_MMIO_UART_TX_FIFO_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, wdata  enqueue (ignored while full)
//   pop, rdata   dequeue (ignored while empty); rdata shows the head entry
//   full, empty  occupancy flags
//   count        number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
`ifdef SVC_RV_MMIO_UART_TX_FIFO_EN
module svc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule
`endif

// File: rtl/svc_rv_mmio_uart_tx.sv
// svc_rv_mmio_uart_tx
// MMIO UART transmitter (8N1) that answers reads with BRAM timing.
// Registers (addr[3:2]): 0 TXDATA (wo), 1 STATUS, 2 DIVISOR, 3 reserved.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rd_en, rd_addr, rd_data       read strobe/address, registered read data
//   wr_en, wr_addr, wr_data, wr_strb  write strobe/address/data/byte enables
//   txd                           serial output, idle high
// Build option: SVC_RV_MMIO_UART_TX_FIFO_EN selects a FIFO_DEPTH-entry
// svc_sync_fifo; otherwise a single holding register buffers one byte.
module svc_rv_mmio_uart_tx
  import svc_rv_mmio_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic        txd
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       rd_sel;
  logic [1:0]       wr_sel;
  logic             txdata_wr;
  logic             status_clr;
  logic             divisor_wr;
  logic             push;
  logic             pop;
  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] level;
  logic [7:0]       head;
  logic             overflow;
  logic [15:0]      div_reg;
  logic [15:0]      div_merged;
  tx_state_t        state;
  logic [15:0]      cnt;
  logic [15:0]      div_lat;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [31:0]      rd_next;
  logic             unused_bits;

  assign unused_bits = &{1'b0, rd_addr[31:4], rd_addr[1:0], wr_addr[31:4],
                         wr_addr[1:0], wr_data[31:16], wr_strb[3:2]};

  assign rd_sel     = rd_addr[3:2];
  assign wr_sel     = wr_addr[3:2];
  assign txdata_wr  = wr_en && (wr_sel == REG_TXDATA) && wr_strb[0];
  assign status_clr = wr_en && (wr_sel == REG_STATUS) && wr_strb[0] && wr_data[3];
  assign divisor_wr = wr_en && (wr_sel == REG_DIVISOR) && (wr_strb[1:0] != 2'b00);

  // Fullness is the pre-cycle value, so a same-cycle pop never rescues a push.
  assign push = txdata_wr && !buf_full;

  // A frame starts either from idle or on the last stop-bit cycle of the
  // previous frame, which is what makes back-to-back frames gapless.
  assign pop = !buf_empty &&
               ((state == TX_IDLE) || ((state == TX_STOP) && (cnt == 16'd0)));

`ifdef SVC_RV_MMIO_UART_TX_FIFO_EN
  svc_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(wr_data[7:0]),
    .pop  (pop),
    .rdata(head),
    .full (buf_full),
    .empty(buf_empty),
    .count(level)
  );
`else
  logic       hold_valid;
  logic [7:0] hold_byte;

  // push only happens while empty and pop only while full, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_byte  <= 8'h00;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_byte  <= wr_data[7:0];
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_empty = !hold_valid;
  assign level     = CNT_W'(hold_valid);
  assign head      = hold_byte;
`endif

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (txdata_wr && buf_full) begin
      overflow <= 1'b1;
    end else if (status_clr) begin
      overflow <= 1'b0;
    end
  end

  // Byte-lane merge of a divisor write; zero would stall the bit timer.
  always_comb begin
    div_merged = div_reg;
    if (wr_strb[0]) div_merged[7:0]  = wr_data[7:0];
    if (wr_strb[1]) div_merged[15:8] = wr_data[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= DIV_RESET;
    end else if (divisor_wr) begin
      div_reg <= (div_merged == 16'd0) ? 16'd1 : div_merged;
    end
  end

  // Transmit engine. cnt counts div_lat-1 down to 0 within each bit period;
  // txd is registered and changes together with the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      cnt     <= 16'd0;
      div_lat <= DIV_RESET;
      shift   <= 8'h00;
      bit_idx <= 3'd0;
      txd     <= 1'b1;
    end else if (pop) begin
      state   <= TX_START;
      shift   <= head;
      div_lat <= div_reg;
      cnt     <= div_reg - 16'd1;
      txd     <= 1'b0;
    end else begin
      case (state)
        TX_START: begin
          if (cnt == 16'd0) begin
            state   <= TX_DATA;
            cnt     <= div_lat - 16'd1;
            bit_idx <= 3'd0;
            txd     <= shift[0];
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt == 16'd0) begin
            cnt <= div_lat - 16'd1;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (cnt == 16'd0) begin
            state <= TX_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_next = 32'h0;
    case (rd_sel)
      REG_STATUS: begin
        rd_next[STATUS_BUSY]               = (state != TX_IDLE);
        rd_next[STATUS_FULL]               = buf_full;
        rd_next[STATUS_EMPTY]              = buf_empty;
        rd_next[STATUS_OVERFLOW]           = overflow;
        rd_next[STATUS_LEVEL_LSB +: 8]     = 8'(level);
      end
      REG_DIVISOR:  rd_next[15:0] = div_reg;
      REG_TXDATA:   rd_next = 32'h0;
      REG_RESERVED: rd_next = 32'h0;
      default:      rd_next = 32'h0;
    endcase
  end

  // Registered read port; holds its value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 32'h0;
    end else if (rd_en) begin
      rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_svc_rv_mmio_uart_tx.sv
// tb_svc_rv_mmio_uart_tx
// Scoreboard bench for svc_rv_mmio_uart_tx. A cycle-level behavioural model
// (byte queue + "frame busy until cycle N") predicts read data and serial
// frames; two monitors compare registered reads and the txd waveform.
// Honours SVC_RV_MMIO_UART_TX_FIFO_EN to pick the buffer capacity.
module tb_svc_rv_mmio_uart_tx;

  localparam int          FIFO_DEPTH = 8;
  localparam logic [15:0] DIV_RESET  = 16'd868;
`ifdef SVC_RV_MMIO_UART_TX_FIFO_EN
  localparam int CAPACITY = FIFO_DEPTH;
`else
  localparam int CAPACITY = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  logic [31:0] rd_data;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;
  logic [3:0]  wr_strb = 4'h0;
  logic        txd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  svc_rv_mmio_uart_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_strb(wr_strb),
    .txd    (txd)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start;
  } frame_t;

  typedef struct {
    int          due;
    logic [31:0] value;
    logic [1:0]  sel;
  } read_t;

  frame_t exp_frames[$];
  read_t  exp_reads[$];

  // Reference model state
  logic [7:0]  m_q[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_div = DIV_RESET;
  int          m_last = -1;
  int          m_sz;
  logic [31:0] m_rv;
  logic [15:0] m_nd;
  logic [7:0]  m_b;

  function automatic string sel_name(input logic [1:0] sel);
    case (sel)
      2'd0:    return "read_txdata";
      2'd1:    return "read_status";
      2'd2:    return "read_divisor";
      default: return "read_reserved";
    endcase
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model: everything is evaluated on the state before this edge, then updated.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_div  = DIV_RESET;
      m_last = -1;
      exp_frames.delete();
      exp_reads.delete();
    end else begin
      m_sz = m_q.size();
      if (rd_en) begin
        m_rv = 32'h0;
        if (rd_addr[3:2] == 2'd1) begin
          m_rv[0]    = (cyc <= m_last);
          m_rv[1]    = (m_sz >= CAPACITY);
          m_rv[2]    = (m_sz == 0);
          m_rv[3]    = m_ovf;
          m_rv[15:8] = 8'(m_sz);
        end else if (rd_addr[3:2] == 2'd2) begin
          m_rv[15:0] = m_div;
        end
        exp_reads.push_back('{due: cyc + 1, value: m_rv, sel: rd_addr[3:2]});
      end
      if (m_sz > 0 && cyc >= m_last) begin
        m_b = m_q.pop_front();
        exp_frames.push_back('{data: m_b, div: int'(m_div), start: cyc + 1});
        m_last = cyc + 10 * int'(m_div);
      end
      if (wr_en) begin
        case (wr_addr[3:2])
          2'd0: if (wr_strb[0]) begin
            if (m_sz >= CAPACITY) m_ovf = 1'b1;
            else m_q.push_back(wr_data[7:0]);
          end
          2'd1: if (wr_strb[0] && wr_data[3]) m_ovf = 1'b0;
          2'd2: if (wr_strb[1:0] != 2'b00) begin
            m_nd = m_div;
            if (wr_strb[0]) m_nd[7:0] = wr_data[7:0];
            if (wr_strb[1]) m_nd[15:8] = wr_data[15:8];
            m_div = (m_nd == 16'd0) ? 16'd1 : m_nd;
          end
          default: ;
        endcase
      end
    end
    cyc = cyc + 1;
  end

  // Read monitor
  read_t r_cur;
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_reads.size() > 0 && exp_reads[0].due <= cyc) begin
        r_cur = exp_reads.pop_front();
        check_output(sel_name(r_cur.sel), rd_data, r_cur.value);
      end
    end
  end

  // Serial monitor: frames are timed in cycles against the model's start cycle.
  frame_t f_cur;
  logic   mon_active = 1'b0;
  logic   mon_ok = 1'b0;
  int     mon_bit = 0;
  int     mon_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd !== 1'b1) begin
        tests++;
        if (exp_frames.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_frame: txd went low at cycle %0d, expected idle", cyc);
          f_cur  = '{data: 8'h00, div: 1, start: cyc};
          mon_ok = 1'b0;
        end else begin
          f_cur  = exp_frames.pop_front();
          mon_ok = 1'b1;
          check_output("frame_start_cycle", cyc, f_cur.start);
        end
        mon_active = 1'b1;
        mon_bit    = 0;
        mon_cnt    = 0;
      end
      if (mon_active) begin
        if (mon_ok && txd !== frame_bit(f_cur.data, mon_bit)) begin
          fails++;
          mon_ok = 1'b0;
          $display("[TB] FAIL frame_bit: byte 0x%02h bit %0d cycle %0d got %b expected %b",
                   f_cur.data, mon_bit, cyc, txd, frame_bit(f_cur.data, mon_bit));
        end
        mon_cnt++;
        if (mon_cnt == f_cur.div) begin
          mon_cnt = 0;
          mon_bit++;
          if (mon_bit == 10) mon_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic apply_stimulus(input logic do_rd, input logic [1:0] rsel,
                                input logic do_wr, input logic [1:0] wsel,
                                input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] ra;
    logic [31:0] wa;
    ra = $urandom();
    wa = $urandom();
    ra[3:2] = rsel;
    wa[3:2] = wsel;
    rd_en   = do_rd;
    rd_addr = ra;
    wr_en   = do_wr;
    wr_addr = wa;
    wr_data = data;
    wr_strb = strb;
    tick();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_strb = 4'h0;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [31:0] data,
                           input logic [3:0] strb);
    apply_stimulus(1'b0, 2'd0, 1'b1, sel, data, strb);
  endtask

  task automatic read_reg(input logic [1:0] sel);
    apply_stimulus(1'b1, sel, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  // Polls STATUS every cycle until the model says all frames are out.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((m_q.size() > 0 || cyc <= m_last + 1) && n < budget) begin
      read_reg(2'd1);
      n++;
    end
    check_output("idle_within_budget", 32'(n >= budget), 32'h0);
    idle(3);
  endtask

  initial begin
    int k;
    logic        do_rd;
    logic        do_wr;
    logic [1:0]  rs;
    logic [1:0]  ws;
    logic [31:0] d;
    logic [3:0]  s;

    idle(3);
    rst = 1'b0;
    check_output("txd_after_reset", 32'(txd), 32'h1);
    check_output("rd_data_after_reset", rd_data, 32'h0);
    read_reg(2'd1);
    read_reg(2'd2);
    read_reg(2'd0);
    read_reg(2'd3);
    idle(2);

    // Single frame at 4 clocks per bit
    write_reg(2'd2, 32'h0000_0004, 4'b0011);
    write_reg(2'd0, 32'h0000_0055, 4'b0001);
    wait_idle(200);

    // Back-to-back frames at 2 clocks per bit
    write_reg(2'd2, 32'h0000_0002, 4'b0011);
    write_reg(2'd0, 32'h0000_00A0, 4'b0001);
    write_reg(2'd0, 32'h0000_000F, 4'b0001);
    write_reg(2'd0, 32'h0000_00FF, 4'b0001);
    wait_idle(200);

    // Overflow with a slow divisor
    write_reg(2'd2, 32'h0000_0064, 4'b0011);
    for (int i = 0; i < 10; i++) write_reg(2'd0, 32'(8'h30 + i), 4'b0001);
    read_reg(2'd1);
    write_reg(2'd1, 32'h0000_0008, 4'b0001);
    read_reg(2'd1);
    wait_idle(12000);

    // Divisor change while a frame is in flight
    write_reg(2'd2, 32'h0000_0004, 4'b0011);
    write_reg(2'd0, 32'h0000_00C3, 4'b0001);
    idle(2);
    write_reg(2'd0, 32'h0000_003C, 4'b0001);
    idle(8);
    write_reg(2'd2, 32'h0000_0008, 4'b0011);
    read_reg(2'd2);
    wait_idle(400);
    write_reg(2'd2, 32'h0000_0000, 4'b0011);
    read_reg(2'd2);
    write_reg(2'd2, 32'h0000_0008, 4'b0011);

    // Reset in the middle of the data bits
    write_reg(2'd0, 32'h0000_0000, 4'b0001);
    idle(20);
    #2;
    rst = 1'b1;
    #1;
    check_output("txd_on_reset_assert", 32'(txd), 32'h1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    read_reg(2'd1);
    read_reg(2'd2);
    idle(100);
    check_output("txd_idle_after_reset", 32'(txd), 32'h1);

    // Randomised traffic
    write_reg(2'd2, 32'h0000_0003, 4'b0011);
    for (int i = 0; i < 400; i++) begin
      do_rd = ($urandom_range(0, 1) == 1);
      do_wr = ($urandom_range(0, 9) < 4);
      rs    = 2'($urandom_range(0, 3));
      k     = $urandom_range(0, 9);
      ws    = (k < 6) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
      d     = $urandom();
      s     = 4'($urandom_range(0, 15));
      if (ws == 2'd0 && $urandom_range(0, 4) != 0) s[0] = 1'b1;
      if (ws == 2'd2) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 4));
      apply_stimulus(do_rd, rs, do_wr, ws, d, s);
    end
    wait_idle(20000);

    check_output("frames_outstanding", 32'(exp_frames.size()), 32'h0);
    check_output("reads_outstanding", 32'(exp_reads.size()), 32'h0);
    check_output("monitor_idle_at_end", 32'(mon_active), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
